booth_r4_seq_mult: RTL

//  Iterative signed radix-4 Booth multiplier: WIDTH x WIDTH -> 2*WIDTH product.

---
 rtl/booth_r4_seq_mult.sv | 99 +++++++++
 1 files changed

// File: rtl/booth_r4_seq_mult.sv
// Iterative signed radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, one Booth triplet per clock.
// Latency: done pulses in the cycle after edge ITER+1 from the accepted start; one result per ITER+2 clocks.
// Backpressure: start is taken only while idle (busy=0); requests while busy are dropped, not queued.
module booth_r4_seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     x_in,
    input  logic [WIDTH-1:0]     y_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int ITER = WIDTH / 2;
    localparam int CW   = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     x_r;
    logic [WIDTH+1:0]     ybuf;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 last;
    logic [2:0]           trip;
    logic [WIDTH:0]       xo;
    logic [2*WIDTH-1:0]   pp_ext;
    logic [2*WIDTH-1:0]   pp_shift;

    assign last = (cnt == CW'(ITER - 1));
    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !abort) state_nxt = RUN;
            RUN:     if (abort) state_nxt = IDLE;
                     else if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Negative selections are one's complement here; the +sign below completes the negation,
    // and doing it at 2W bits keeps -2*(-2^(W-1)) exact.
    always_comb begin
        trip = ybuf[2:0];
        case (trip)
            3'b000:          xo = '0;
            3'b001, 3'b010:  xo = {x_r[WIDTH-1], x_r};
            3'b011:          xo = {x_r, 1'b0};
            3'b100:          xo = ~{x_r, 1'b0};
            3'b101, 3'b110:  xo = ~{x_r[WIDTH-1], x_r};
            default:         xo = '1;
        endcase
        pp_ext   = {{(WIDTH-1){xo[WIDTH]}}, xo} + (2*WIDTH)'(trip[2]);
        pp_shift = pp_ext << {cnt, 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x_r     <= '0;
            ybuf    <= '0;
            acc     <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        x_r  <= x_in;
                        ybuf <= {y_in[WIDTH-1], y_in, 1'b0};
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    if (!abort) begin
                        acc  <= acc + pp_shift;
                        ybuf <= {{2{ybuf[WIDTH+1]}}, ybuf[WIDTH+1:2]};
                        cnt  <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    product <= acc;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
